aes_128_enc_iter: RTL and testbench
===================================

// Module: aes_128_enc_iter
// PURPOSE
//  Iterative AES-128 encryption core (FIPS-197): one round per clock, round keys expanded
//  on the fly from the 128-bit cipher key. Forward-direction counterpart of inv_aes_128.
//  Sits between a valid/ready plaintext source and a valid/ready ciphertext sink.
//  Output feeds inv_aes_128 for loopback checking.
// PARAMETERS
//  NR             10  number of rounds; only 10 (AES-128) is supported
//  CLEAR_ON_XFER  1   1: ciphertext register is zeroed when the output handshake completes
// PORTS
//  clk         in   1    system clock, all logic on rising edge
//  rst         in   1    synchronous, active-high reset
//  in_valid    in   1    plaintext/key present
//  in_ready    out  1    core idle, can accept a block
//  plaintext   in   128  input block; [127:120] = state byte 0, column-major
//  key         in   128  cipher key, same byte order
//  out_valid   out  1    ciphertext valid, held until accepted
//  out_ready   in   1    sink accepts ciphertext
//  ciphertext  out  128  result block, same byte order
//  busy        out  1    high while rounds are in progress
//  round       out  4    current round index 0..10, debug
// BEHAVIOUR
//  Reset: state IDLE; in_ready=1, out_valid=0, busy=0, round=0, ciphertext=0,
//   state/round-key/rcon regs zeroed.
//  States: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: in_ready=1. On in_valid&&in_ready (accept edge T): state_reg <= plaintext^key,
//   rkey_reg <= key, rcon <= 8'h01, round <= 1, go RUN. Inputs sampled only at T;
//   later changes to plaintext/key have no effect.
//  RUN, rounds 1..9: state_reg <= MixColumns(ShiftRows(SubBytes(state_reg))) ^ next_rk.
//   next_rk = KeyExpansion(rkey_reg, rcon), which is also loaded into rkey_reg.
//   rcon <= xtime(rcon), giving 01,02,04,08,10,20,40,80,1B,36; round++.
//  RUN, round 10: same round but without MixColumns. ciphertext <= result,
//   out_valid <= 1, go DONE.
//  Latency: out_valid is first high at edge T+10 (10 clocks after accept).
//  DONE: out_valid and ciphertext held stable while out_ready=0 (no drop, no change).
//   On out_valid&&out_ready: out_valid <= 0, go IDLE. If CLEAR_ON_XFER, ciphertext <= 0.
//   in_ready returns the following cycle. Maximum throughput: 1 block per 12 clocks.
//  in_valid while not IDLE: ignored, not queued; in_ready=0 so no handshake occurs.
//  out_ready while not DONE: ignored.
//  busy=1 exactly in RUN. round=0 in IDLE; in DONE it holds the value 10.
//  S-box: combinational 256-entry ROM (16 instances for state, 4 for key schedule);
//   no extra pipeline stage permitted, because the latency above is fixed.
//  GF(2^8) arithmetic: xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 8'h00).
//  Reset mid-operation (any state): abort immediately to reset values.
//   A pending result is discarded; no partial ciphertext is ever visible.
//  Rising in_valid in the same cycle as reset deassert: not accepted until the next edge
//   with rst=0.
// TESTING
//  1 FIPS-197 C.1: pt=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f
//    -> ct=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid at T+10.
//  2 FIPS-197 B: pt=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c
//    -> ct=3925841d02dc09fbdc118597196a0b32; after round 1, state=a49c7ff2689f352b6b5bea43026a5049.
//  3 All-zero pt and key -> 66e94bd4ef8a2c3b884cfa59ca342b2e.
//  4 Backpressure: hold out_ready=0 for 20 cycles, toggle pt/key and pulse in_valid during RUN/DONE
//    -> ct and out_valid stable, in_ready=0, second request not accepted; accepted only after out xfer.
//  5 rst=1 at round 5, then encrypt vector 1 -> outputs zero at reset, then correct ct at T+10.
//  6 Loopback: 1000 random pt/key through this core then inv_aes_128 -> recovered plaintext == pt.

Source files
------------

// File: rtl/aes_128_enc_iter.sv
// Iterative AES-128 encryption core: one full cipher round per clock, with the
// round key derived on the fly from the previous one. Valid/ready on both sides.
module aes_128_enc_iter #(
  parameter int NR            = 10,
  parameter bit CLEAR_ON_XFER = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy,
  output logic [3:0]   round
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = 11'd2047 - {b, 3'b000};
    return SBOX[idx -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_t;

  fsm_t         r_fsm;
  logic [127:0] r_state;
  logic [127:0] r_rkey;
  logic [7:0]   r_rcon;
  logic [3:0]   r_round;
  logic [127:0] r_ct;
  logic         r_out_valid;
  logic         r_in_ready;
  logic         r_busy;

  logic [7:0]   w_sb [16];
  logic [7:0]   w_sr [16];
  logic [7:0]   w_mc [16];
  logic [31:0]  w_kw [4];
  logic [31:0]  w_rot;
  logic [7:0]   w_ksb [4];
  logic [31:0]  w_ktemp;
  logic [31:0]  w_nk [4];
  logic [127:0] w_next_rk;
  logic [127:0] w_rnd_full;
  logic [127:0] w_rnd_last;

  // State byte i = row (i%4), column (i/4); ShiftRows rotates row r left by r.
  for (genvar gi = 0; gi < 16; gi++) begin : g_bytes
    assign w_sb[gi] = sbox(r_state[127-8*gi -: 8]);
    assign w_sr[gi] = w_sb[4*(((gi/4) + (gi%4)) % 4) + (gi%4)];
    assign w_rnd_full[127-8*gi -: 8] = w_mc[gi] ^ w_next_rk[127-8*gi -: 8];
    assign w_rnd_last[127-8*gi -: 8] = w_sr[gi] ^ w_next_rk[127-8*gi -: 8];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_cols
    logic [7:0] a0, a1, a2, a3;
    assign a0 = w_sr[4*gi+0];
    assign a1 = w_sr[4*gi+1];
    assign a2 = w_sr[4*gi+2];
    assign a3 = w_sr[4*gi+3];
    assign w_mc[4*gi+0] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign w_mc[4*gi+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign w_mc[4*gi+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign w_mc[4*gi+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_key
    assign w_kw[gi]  = r_rkey[127-32*gi -: 32];
    assign w_ksb[gi] = sbox(w_rot[31-8*gi -: 8]);
    assign w_next_rk[127-32*gi -: 32] = w_nk[gi];
  end

  // Key schedule step: SubWord(RotWord(w3)) ^ Rcon, then chained XOR.
  assign w_rot   = {w_kw[3][23:0], w_kw[3][31:24]};
  assign w_ktemp = {w_ksb[0] ^ r_rcon, w_ksb[1], w_ksb[2], w_ksb[3]};
  assign w_nk[0] = w_kw[0] ^ w_ktemp;
  assign w_nk[1] = w_kw[1] ^ w_nk[0];
  assign w_nk[2] = w_kw[2] ^ w_nk[1];
  assign w_nk[3] = w_kw[3] ^ w_nk[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm       <= S_IDLE;
      r_state     <= '0;
      r_rkey      <= '0;
      r_rcon      <= '0;
      r_round     <= '0;
      r_ct        <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (in_valid) begin
            r_state    <= plaintext ^ key;
            r_rkey     <= key;
            r_rcon     <= 8'h01;
            r_round    <= 4'd1;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_fsm      <= S_RUN;
          end
        end
        S_RUN: begin
          r_rkey <= w_next_rk;
          r_rcon <= xtime(r_rcon);
          if (r_round == LAST_ROUND) begin
            r_state     <= w_rnd_last;
            r_ct        <= w_rnd_last;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_fsm       <= S_DONE;
          end else begin
            r_state <= w_rnd_full;
            r_round <= r_round + 4'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (CLEAR_ON_XFER) r_ct <= '0;
            r_round    <= 4'd0;
            r_in_ready <= 1'b1;
            r_fsm      <= S_IDLE;
          end
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign ciphertext = r_ct;
  assign busy       = r_busy;
  assign round      = r_round;

endmodule

// File: tb/tb_aes_128_enc_iter.sv
// Scoreboard bench for aes_128_enc_iter: stimulus pushes known-answer ciphertexts,
// a monitor pops and compares on every output handshake.
module tb_aes_128_enc_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic         busy;
  logic [3:0]   round;

  int n_tests = 0;
  int n_fail  = 0;
  logic [127:0] exp_q [$];

  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] R1_B   = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] CT_VT  = 128'h3ad78e726c1ec02b7ebfe92b23d9ec34;
  localparam logic [127:0] CT_VK  = 128'h0edd33d3c621e546455bd8ba1418bec8;

  aes_128_enc_iter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .plaintext(plaintext), .key(key), .out_valid(out_valid), .out_ready(out_ready),
    .ciphertext(ciphertext), .busy(busy), .round(round)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("[TB] ok   %s: %h", nm, act);
    end
  endtask

  // Presents a block and returns #1 after the accept edge.
  task automatic send(input logic [127:0] pt, input logic [127:0] k, input logic [127:0] exp_ct);
    int n = 0;
    plaintext = pt;
    key       = k;
    in_valid  = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 128'(in_ready), 128'd1);
    end else begin
      @(posedge clk);
      exp_q.push_back(exp_ct);
      #1;
      in_valid = 1'b0;
      check("accept_round1", 128'(round), 128'd1);
      check("accept_busy", 128'({busy, in_ready}), 128'b10);
    end
  endtask

  // Counts edges from the accept edge until out_valid rises; must be 10.
  task automatic wait_out(input string nm, input int already);
    int n = already;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check(nm, 128'(n), 128'd10);
  endtask

  // Monitor: compare on each output handshake, then check the post-transfer state.
  initial begin
    logic [127:0] exp;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", ciphertext, 128'd0);
        end else begin
          exp = exp_q.pop_front();
          check("ciphertext", ciphertext, exp);
          @(posedge clk); #1;
          check("post_xfer_cleared", {ciphertext[123:0], out_valid, in_ready, round[1:0]},
                {124'd0, 1'b0, 1'b1, 2'b00});
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [127:0] hold_ct;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; plaintext = '0; key = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 128'(in_ready), 128'd1);
    check("reset_out_valid", 128'(out_valid), 128'd0);
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_round", 128'(round), 128'd0);
    check("reset_ciphertext", ciphertext, 128'd0);
    rst = 1'b0;
    out_ready = 1'b1;

    // FIPS-197 C.1 with latency check
    send(PT_C1, KEY_C1, CT_C1);
    wait_out("latency_c1", 0);
    check("done_round", 128'(round), 128'd10);

    // FIPS-197 Appendix B, with the state after round 1
    send(PT_B, KEY_B, CT_B);
    @(posedge clk); #1;
    check("round1_state", dut.r_state, R1_B);
    wait_out("latency_b", 1);

    send('0, '0, CT_Z);
    wait_out("latency_zero", 0);
    send(128'h80000000000000000000000000000000, '0, CT_VT);
    wait_out("latency_vartxt", 0);
    send('0, 128'h80000000000000000000000000000000, CT_VK);
    wait_out("latency_varkey", 0);

    // Backpressure: input noise during RUN, 20-cycle hold in DONE
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(PT_B, KEY_B, CT_B);
    n = 0;
    while (!out_valid && n < 40) begin
      plaintext = {$urandom, $urandom, $urandom, $urandom};
      key       = {$urandom, $urandom, $urandom, $urandom};
      in_valid  = n[0];
      @(posedge clk); #1; n++;
      if (!out_valid) check("run_in_ready_low", 128'(in_ready), 128'd0);
    end
    check("latency_bp", 128'(n), 128'd10);
    hold_ct = CT_B;
    plaintext = '0; key = '0; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("hold_stable", {ciphertext, out_valid, in_ready, busy, round},
            {hold_ct, 1'b1, 1'b0, 1'b0, 4'd10});
    end
    out_ready = 1'b1;
    send('0, '0, CT_Z);
    wait_out("latency_after_bp", 0);

    // Reset in the middle of round processing
    send(PT_C1, KEY_C1, CT_C1);
    n = 0;
    while (round != 4'd5 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("reached_round5", 128'(round), 128'd5);
    rst = 1'b1;
    @(posedge clk); #1;
    void'(exp_q.pop_back());
    check("midrst_outputs", {ciphertext, out_valid, busy, round, in_ready},
          {128'd0, 1'b0, 1'b0, 4'd0, 1'b1});
    rst = 1'b0;
    send(PT_C1, KEY_C1, CT_C1);
    wait_out("latency_after_rst", 0);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
